// File: rtl/buttons_arbiter_db.sv
// Debounced multi-button front end with single-press arbiter.
// Accepts one isolated press at a time; chords block until all released.
module buttons_arbiter_db #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] action,
  output logic             action_valid,
  output logic             pressed,
  output logic             multi
);

  localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW     = $clog2(HC_MAX + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] DLY_M1  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_M1  = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_BLOCKED
  } state_t;

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s;
  logic [N_BTN-1:0] r_db;
  logic [CW-1:0]    r_cnt [N_BTN];

  state_t           r_state;
  state_t           w_nstate;
  logic [N_BTN-1:0] r_lat;
  logic [N_BTN-1:0] w_lat_n;
  logic [HW-1:0]    r_hc;
  logic [HW-1:0]    w_hc_n;
  logic             r_first;
  logic             w_first_n;
  logic [N_BTN-1:0] w_act;

  logic [N_BTN-1:0] r_action;
  logic             r_valid;
  logic             r_pressed;
  logic             r_multi;

  logic             w_nz;
  logic             w_multi;
  logic [HW-1:0]    w_tgt;

  assign w_nz    = |r_db;
  assign w_multi = |(r_db & (r_db - N_BTN'(1)));
  assign w_tgt   = r_first ? DLY_M1 : PER_M1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s  <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s  <= r_s1;
    end
  end

  // db follows s only after CNT_MAX mismatches plus one more confirming sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db <= '0;
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (r_s[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_db[i]  <= r_s[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    w_nstate  = r_state;
    w_lat_n   = r_lat;
    w_hc_n    = r_hc;
    w_first_n = r_first;
    w_act     = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_multi) begin
          w_nstate = ST_BLOCKED;
        end else if (w_nz) begin
          w_act     = r_db;
          w_lat_n   = r_db;
          w_hc_n    = '0;
          w_first_n = 1'b1;
          w_nstate  = ST_HELD;
        end
      end
      ST_HELD: begin
        if (r_db == r_lat) begin
          if (REPEAT_EN != 0) begin
            if (r_hc == w_tgt) begin
              w_act     = r_lat;
              w_hc_n    = '0;
              w_first_n = 1'b0;
            end else begin
              w_hc_n = r_hc + HW'(1);
            end
          end
        end else begin
          w_hc_n    = '0;
          w_first_n = 1'b1;
          w_nstate  = w_nz ? ST_BLOCKED : ST_IDLE;
        end
      end
      ST_BLOCKED: begin
        if (!w_nz) w_nstate = ST_IDLE;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lat     <= '0;
      r_hc      <= '0;
      r_first   <= 1'b1;
      r_action  <= '0;
      r_valid   <= 1'b0;
      r_pressed <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_lat     <= w_lat_n;
      r_hc      <= w_hc_n;
      r_first   <= w_first_n;
      r_action  <= w_act;
      r_valid   <= |w_act;
      r_pressed <= w_nz;
      r_multi   <= w_multi;
    end
  end

  assign action       = r_action;
  assign action_valid = r_valid;
  assign pressed      = r_pressed;
  assign multi        = r_multi;

endmodule

// File: tb/tb_buttons_arbiter_db.sv
// Directed bench for buttons_arbiter_db, one instance
// without repeat and one with repeat, sharing stimulus.
module tb_buttons_arbiter_db;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_raw = '0;

  logic [2:0] act0, act1;
  logic       v0, v1, p0, p1, m0, m1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  buttons_arbiter_db #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .action(act0), .action_valid(v0),
    .pressed(p0), .multi(m0)
  );

  buttons_arbiter_db #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .action(act1), .action_valid(v1),
    .pressed(p1), .multi(m1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    btn_raw = '0;
    repeat (n) tick();
  endtask

  // accepted press: one action exactly at edge 7, nothing else
  task automatic press_once(input string nm, input logic [2:0] b);
    btn_raw = b;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk($sformatf("%s act0 e%0d", nm, e), {v0, act0},
          (e == 7) ? {1'b1, b} : 4'h0);
    end
    chk({nm, " pressed"}, p0, 1'b1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst act0", {v0, act0}, 4'h0);
    chk("rst act1", {v1, act1}, 4'h0);
    chk("rst pressed", {p0, p1}, 2'b00);
    chk("rst multi", {m0, m1}, 2'b00);
    rst_n = 1'b1;
    tick();

    // single press, no repeat on dut0
    btn_raw = 3'b010;
    for (int e = 0; e < 21; e++) begin
      tick();
      chk($sformatf("t1 act0 e%0d", e), {v0, act0},
          (e == 7) ? 4'b1010 : 4'h0);
      if (e == 6) chk("t1 pressed e6", p0, 1'b0);
      if (e == 7) chk("t1 pressed e7", p0, 1'b1);
      if (e == 15) chk("t1 act1 e15", {v1, act1}, 4'b1010);
    end
    idle(10);
    chk("t1 released", p0, 1'b0);

    // 3-clock glitch on bit0 is filtered
    btn_raw = 3'b001;
    for (int e = 0; e < 14; e++) begin
      if (e == 3) btn_raw = '0;
      tick();
      chk($sformatf("t2 act0 e%0d", e), {v0, act0}, 4'h0);
      chk($sformatf("t2 pressed e%0d", e), p0, 1'b0);
    end

    // simultaneous chord blocks; later single press accepted
    btn_raw = 3'b101;
    for (int e = 0; e < 11; e++) begin
      tick();
      chk($sformatf("t3 act0 e%0d", e), {v0, act0}, 4'h0);
      if (e == 6 || e == 7)
        chk($sformatf("t3 multi e%0d", e), m0, (e == 7));
    end
    idle(10);
    chk("t3 multi off", m0, 1'b0);
    press_once("t3b", 3'b100);
    idle(10);

    // hold bit0, then add bit2: blocked until full release
    press_once("t4", 3'b001);
    btn_raw = 3'b101;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk($sformatf("t4 chord act0 e%0d", e), {v0, act0}, 4'h0);
    end
    chk("t4 multi", m0, 1'b1);
    chk("t4 pressed", p0, 1'b1);
    btn_raw = 3'b001;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk($sformatf("t4 partial e%0d", e), {v0, act0}, 4'h0);
    end
    idle(12);
    chk("t4 released", {p0, m0}, 2'b00);
    press_once("t4b", 3'b010);
    idle(10);

    // auto-repeat on dut1
    btn_raw = 3'b001;
    for (int e = 0; e < 26; e++) begin
      tick();
      chk($sformatf("t5 act1 e%0d", e), {v1, act1},
          (e == 7 || e == 15 || e == 18 || e == 21 || e == 24)
            ? 4'b1001 : 4'h0);
      if (e > 7)
        chk($sformatf("t5 act0 e%0d", e), {v0, act0}, 4'h0);
    end
    btn_raw = '0;
    for (int r = 0; r < 12; r++) begin
      tick();
      chk($sformatf("t5 rel act1 r%0d", r), {v1, act1},
          (r == 1 || r == 4) ? 4'b1001 : 4'h0);
    end
    idle(4);

    // reset mid-repeat
    btn_raw = 3'b010;
    for (int e = 0; e < 17; e++) tick();
    rst_n = 1'b0;
    #1;
    chk("t6 rst out0", {v0, act0, p0, m0}, 6'h0);
    chk("t6 rst out1", {v1, act1, p1, m1}, 6'h0);
    tick();
    tick();
    chk("t6 rst held", {v1, act1, p1}, 5'h0);
    rst_n = 1'b1;
    for (int e = 0; e < 13; e++) begin
      tick();
      chk($sformatf("t6 act0 e%0d", e), {v0, act0},
          (e == 7) ? 4'b1010 : 4'h0);
      chk($sformatf("t6 act1 e%0d", e), {v1, act1},
          (e == 7) ? 4'b1010 : 4'h0);
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/buttons_arbiter_db.md
BUTTONS_ARBITER_DB -- requirements
Module: buttons_arbiter_db

Interface
REQ-001 Parameter N_BTN, default 3, number of button channels (>=2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable clocks required to accept a level change (>=1).
REQ-003 Parameter REPEAT_EN, default 0, 1 enables auto-repeat of held single button.
REQ-004 Parameter REPEAT_DELAY, default 64, clocks from first action to first repeat (>=1).
REQ-005 Parameter REPEAT_PERIOD, default 16, clocks between subsequent repeats (>=1).
REQ-006 clk  input  1  single system clock, all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 btn_raw  input  N_BTN  raw asynchronous button levels, 1 = pressed, bit i = channel i.
REQ-009 action  output  N_BTN  one-hot action pulse, bit i = channel i accepted.
REQ-010 action_valid  output  1  one-cycle strobe, high exactly when action != 0.
REQ-011 pressed  output  1  level, debounced vector nonzero.
REQ-012 multi  output  1  level, two or more debounced bits set.
REQ-013 All outputs SHALL be registered.

Function
REQ-014 Each btn_raw bit SHALL pass a 2-flop synchronizer; synchronized vector = s.
REQ-015 Each channel SHALL have an independent counter; s[i]==db[i] clears it; s[i]!=db[i] increments; at DEBOUNCE_CYCLES consecutive mismatches db[i] <= s[i], counter cleared.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES clocks at s SHALL not change db.
REQ-017 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); counter SHALL never wrap.
REQ-018 Arbiter FSM states: IDLE, HELD, BLOCKED.
REQ-019 IDLE, db==0: stay, no action.
REQ-020 IDLE, db has exactly one bit i: action = one-hot i, action_valid = 1 for one cycle, latch i, go HELD.
REQ-021 IDLE, db has >=2 bits: no action, go BLOCKED.
REQ-022 HELD, db == latched one-hot: stay, no action unless repeat fires (REQ-024).
REQ-023 HELD, db==0: go IDLE; HELD, any other db value: no action, go BLOCKED.
REQ-024 REPEAT_EN=1: in HELD a hold counter SHALL pulse the latched action REPEAT_DELAY clocks after the initial action, then every REPEAT_PERIOD clocks while held; REPEAT_EN=0: no repeat, hold counter may be optimized away.
REQ-025 Hold counter SHALL clear on every exit from HELD and saturate/reload without wrap.
REQ-026 BLOCKED: no action until db==0, then go IDLE; a later single press from IDLE is accepted normally.
REQ-027 Simultaneous press of two channels in the same db-update cycle SHALL go directly IDLE->BLOCKED, no action.
REQ-028 Release-then-repress of same channel SHALL produce a new action (requires pass through IDLE).
REQ-029 pressed = |db, multi = popcount(db)>=2, each registered, one clock after db.
REQ-030 Latency: raw level held stable from rising edge k -> db updates at edge k+2+DEBOUNCE_CYCLES, action registered at edge k+3+DEBOUNCE_CYCLES.
REQ-031 action SHALL never have more than one bit set; action_valid SHALL never be high two consecutive cycles except REPEAT_PERIOD==1.

Reset
REQ-032 rst_n low SHALL immediately clear synchronizers, db, all counters, latched index, action, action_valid, pressed, multi; FSM = IDLE.
REQ-033 After rst_n deasserts, a button already held SHALL be treated as a new press after full debounce latency (one action).
REQ-034 Reset mid-debounce or mid-repeat SHALL discard partial counts; no pulse on reset release.

Verification (N_BTN=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-035 btn_raw=3'b010 from edge 0, held -> action=3'b010, action_valid=1 only at edge 7; pressed=1 from edge 7; no further action with REPEAT_EN=0.
REQ-036 btn_raw bit0 pulsed high 3 clocks -> db unchanged, no action, pressed stays 0.
REQ-037 btn_raw=3'b101 from edge 0 -> no action, multi=1 from edge 7; release both, then press 3'b100 -> exactly one action=3'b100.
REQ-038 Hold 3'b001 then add bit2 -> no extra action, FSM BLOCKED, multi=1; release all -> IDLE, pressed=0.
REQ-039 REPEAT_EN=1, hold 3'b001 -> actions at edges 7, 15, 18, 21, ...; release -> repeats stop within DEBOUNCE_CYCLES+3 clocks.
REQ-040 rst_n pulsed low while holding 3'b010 mid-repeat -> all outputs 0 immediately; after release of reset one new action at 3+DEBOUNCE_CYCLES edges.
